// File: rtl/rv_test_pkg.sv
// Shared types for the RISC-V test monitor: FSM state and verdict encoding.
package rv_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    VERDICT_NONE    = 2'd0,
    VERDICT_PASS    = 2'd1,
    VERDICT_FAIL    = 2'd2,
    VERDICT_TIMEOUT = 2'd3
  } verdict_e;

  // Terminal state reached for a given verdict
  function automatic state_e verdict_state(input verdict_e v);
    case (v)
      VERDICT_PASS:    return ST_PASS;
      VERDICT_FAIL:    return ST_FAIL;
      VERDICT_TIMEOUT: return ST_TIMEOUT;
      default:         return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count_q == WIDTH'(MAX));
  assign count  = count_q;

  // Increment when enabled, never past MAX
  always_comb begin
    count_d = count_q;
    if (en && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv_test_monitor.sv
// Test-completion monitor for a RISC-V core: watches the PC for END_PC and
// reports pass/fail from gp (x3), or a timeout after TIMEOUT run cycles.
// Optional build macro TEST_MONITOR_TOHOST_EN adds a tohost store snoop.
module rv_test_monitor
  import rv_test_pkg::*;
#(
  parameter int unsigned       XLEN        = 32,
  parameter logic [XLEN-1:0]   END_PC      = XLEN'(32'h44),
  parameter int unsigned       TIMEOUT     = 5000,
  parameter logic [XLEN-1:0]   TOHOST_ADDR = XLEN'(32'h1000),
  localparam int unsigned      CW          = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic [XLEN-1:0] gp_i,
`ifdef TEST_MONITOR_TOHOST_EN
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
`endif
  output logic            done_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic            timeout_o,
  output logic [XLEN-2:0] test_num_o,
  output logic [CW-1:0]   cycle_count_o
);

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            timeout_q, timeout_d;
  logic [XLEN-2:0] test_num_q, test_num_d;
  logic            cnt_en_c;
  logic            cnt_at_max_c;
  logic            end_hit_c;
  logic            tohost_hit_c;
  logic [XLEN-2:0] tohost_code_c;

  assign end_hit_c = pc_valid_i && (pc_i == END_PC);

`ifdef TEST_MONITOR_TOHOST_EN
  // Only stores with bit0 set to the tohost word signal completion
  assign tohost_hit_c  = mem_we_i && (mem_addr_i == TOHOST_ADDR) && mem_wdata_i[0];
  assign tohost_code_c = mem_wdata_i[XLEN-1:1];
`else
  logic unused_tohost_c;
  assign unused_tohost_c = ^TOHOST_ADDR;
  assign tohost_hit_c    = 1'b0;
  assign tohost_code_c   = '0;
`endif

  // Run-cycle counter, frozen outside RUN and on the completing cycle
  sat_counter #(
    .WIDTH (CW),
    .MAX   (TIMEOUT)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en_c),
    .count  (cycle_count_o),
    .at_max (cnt_at_max_c)
  );

  // Next-state and verdict logic; completion outranks timeout, END_PC outranks tohost
  always_comb begin
    verdict_e verdict_c;
    state_d    = state_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    test_num_d = test_num_q;
    cnt_en_c   = 1'b0;
    verdict_c  = VERDICT_NONE;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (end_hit_c) begin
          if (gp_i == XLEN'(1)) begin
            verdict_c = VERDICT_PASS;
          end else begin
            verdict_c  = VERDICT_FAIL;
            test_num_d = gp_i[XLEN-1:1];
          end
        end else if (tohost_hit_c) begin
          if (tohost_code_c == '0) begin
            verdict_c = VERDICT_PASS;
          end else begin
            verdict_c  = VERDICT_FAIL;
            test_num_d = tohost_code_c;
          end
        end else if (cnt_at_max_c) begin
          verdict_c = VERDICT_TIMEOUT;
        end else begin
          cnt_en_c = 1'b1;
        end

        if (verdict_c != VERDICT_NONE) begin
          state_d   = verdict_state(verdict_c);
          pass_d    = (verdict_c == VERDICT_PASS);
          fail_d    = (verdict_c == VERDICT_FAIL);
          timeout_d = (verdict_c == VERDICT_TIMEOUT);
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and registered outputs; reset overrides any same-cycle completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      test_num_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      test_num_q <= test_num_d;
    end
  end

  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign timeout_o  = timeout_q;
  assign test_num_o = test_num_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor (TIMEOUT=50); tohost checks run when
// TEST_MONITOR_TOHOST_EN is defined.
module tb_rv_test_monitor;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic [XLEN-1:0] gp_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic            mem_we_i;
  logic            done_o, pass_o, fail_o, timeout_o;
  logic [XLEN-2:0] test_num_o;
  logic [CW-1:0]   cycle_count_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rv_test_monitor #(
    .XLEN        (XLEN),
    .END_PC      (32'h44),
    .TIMEOUT     (TIMEOUT),
    .TOHOST_ADDR (32'h1000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .gp_i          (gp_i),
`ifdef TEST_MONITOR_TOHOST_EN
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
`endif
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .test_num_o    (test_num_o),
    .cycle_count_o (cycle_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks {done,pass,fail,timeout}, test number and cycle count together
  task automatic check_all(input string tag, input logic [3:0] flags,
                           input logic [31:0] tnum, input logic [31:0] cnt);
    check({tag, ".flags"}, {28'd0, done_o, pass_o, fail_o, timeout_o}, {28'd0, flags});
    check({tag, ".test_num"}, {1'b0, test_num_o}, tnum);
    check({tag, ".count"}, {26'd0, cycle_count_o}, cnt);
  endtask

  task automatic idle_inputs();
    pc_i        = '0;
    pc_valid_i  = 1'b0;
    gp_i        = '0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
  endtask

  // Reset, release, and run until cycle_count_o == n
  task automatic restart(input int n);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (n) tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_all("reset", 4'b0000, 0, 0);

    // Pass at count 20
    rst = 1'b0;
    tick();
    check_all("run_start", 4'b0000, 0, 0);
    repeat (20) tick();
    check_all("pre_pass", 4'b0000, 0, 20);
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd1;
    tick();
    check_all("pass20", 4'b1100, 0, 20);
    gp_i = 32'd9;
    repeat (3) tick();
    check_all("pass_sticky", 4'b1100, 0, 20);

    // Fail with gp=7 -> test 3
    restart(5);
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd7;
    tick();
    check_all("fail_gp7", 4'b1010, 3, 5);

    // END_PC ignored when not valid, other PCs ignored when valid
    restart(3);
    pc_i = 32'h44; pc_valid_i = 1'b0; gp_i = 32'd1;
    tick();
    check_all("pc_invalid", 4'b0000, 0, 4);
    pc_i = 32'h40; pc_valid_i = 1'b1;
    tick();
    check_all("pc_other", 4'b0000, 0, 5);

    // gp=0 is a fail with test 0
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd0;
    tick();
    check_all("fail_gp0", 4'b1010, 0, 5);

    // Timeout one cycle after count reaches 50
    restart(50);
    check_all("at_limit", 4'b0000, 0, 50);
    tick();
    check_all("timeout", 4'b1001, 0, 50);
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd1;
    repeat (2) tick();
    check_all("timeout_sticky", 4'b1001, 0, 50);

    // Completion beats timeout on the same cycle
    restart(50);
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd1;
    tick();
    check_all("pass_over_timeout", 4'b1100, 0, 50);

    // Large gp value -> test number is gp>>1
    restart(7);
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'hFFFF_FFFE;
    tick();
    check_all("fail_big", 4'b1010, 32'h7FFF_FFFF, 7);

    // Reset mid-run, and completion ignored while rst is high
    restart(10);
    rst = 1'b1;
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd1;
    tick();
    check_all("mid_reset", 4'b0000, 0, 0);
    idle_inputs();
    rst = 1'b0;
    tick();
    check_all("rerun0", 4'b0000, 0, 0);
    tick();
    check_all("rerun1", 4'b0000, 0, 1);

`ifdef TEST_MONITOR_TOHOST_EN
    // tohost store 0xB -> fail test 5
    restart(4);
    mem_we_i = 1'b1; mem_addr_i = 32'h1000; mem_wdata_i = 32'h0000_000B;
    tick();
    check_all("tohost_fail", 4'b1010, 5, 4);

    // tohost store 0x1 -> pass
    restart(4);
    mem_we_i = 1'b1; mem_addr_i = 32'h1000; mem_wdata_i = 32'h1;
    tick();
    check_all("tohost_pass", 4'b1100, 0, 4);

    // bit0=0 store and wrong address are ignored
    restart(2);
    mem_we_i = 1'b1; mem_addr_i = 32'h1000; mem_wdata_i = 32'hA;
    tick();
    check_all("tohost_bit0", 4'b0000, 0, 3);
    mem_addr_i = 32'h1004; mem_wdata_i = 32'h1;
    tick();
    check_all("tohost_addr", 4'b0000, 0, 4);

    // END_PC beats tohost on the same cycle
    mem_addr_i = 32'h1000; mem_wdata_i = 32'hB;
    pc_i = 32'h44; pc_valid_i = 1'b1; gp_i = 32'd1;
    tick();
    check_all("endpc_over_tohost", 4'b1100, 0, 4);
`else
    // tohost-shaped traffic has no path into the design in this build
    restart(2);
    mem_we_i = 1'b1; mem_addr_i = 32'h1000; mem_wdata_i = 32'hB;
    tick();
    check_all("no_tohost", 4'b0000, 0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rv_test_monitor.md
RV_TEST_MONITOR -- requirements
Module: rv_test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, core register/PC width.
REQ-002 SHALL have parameter END_PC, default 32'h44, PC value signalling test completion.
REQ-003 SHALL have parameter TIMEOUT, default 5000, max run cycles before timeout; CW = clog2(TIMEOUT+1).
REQ-004 SHALL have parameter TOHOST_ADDR, default 32'h1000, tohost word address (used only with macro).
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port pc_i  in  XLEN  core PC.
REQ-008 SHALL have port pc_valid_i  in  1  pc_i holds a retiring/fetched PC this cycle.
REQ-009 SHALL have port gp_i  in  XLEN  core register x3 (gp).
REQ-010 SHALL have ports mem_we_i (1), mem_addr_i (XLEN), mem_wdata_i (XLEN), inputs, store snoop; present only with TEST_MONITOR_TOHOST_EN.
REQ-011 SHALL have port done_o  out  1  test finished (any verdict), sticky.
REQ-012 SHALL have ports pass_o, fail_o, timeout_o  out  1 each  one-hot verdict, sticky.
REQ-013 SHALL have port test_num_o  out  XLEN-1  failing test number.
REQ-014 SHALL have port cycle_count_o  out  CW  cycles spent in RUN.

Function
REQ-015 SHALL implement states IDLE, RUN, PASS, FAIL, TIMEOUT.
REQ-016 SHALL go IDLE->RUN on the first cycle after rst deasserts.
REQ-017 SHALL in RUN increment cycle_count_o by 1 per cycle, saturating at TIMEOUT.
REQ-018 SHALL in RUN, when pc_valid_i=1 and pc_i==END_PC, sample gp_i that cycle: gp_i==1 -> PASS; else -> FAIL with test_num_o = gp_i>>1.
REQ-019 SHALL in RUN, when cycle_count_o==TIMEOUT and no completion event occurs that cycle, go to TIMEOUT.
REQ-020 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-021 SHALL register verdict outputs: asserted the cycle after the completion event (1-cycle latency).
REQ-022 SHALL hold PASS/FAIL/TIMEOUT until rst; further pc/gp/store activity ignored, cycle_count_o frozen.
REQ-023 SHALL keep pass_o, fail_o, timeout_o mutually exclusive; done_o = OR of the three.
REQ-024 SHALL ignore pc_i when pc_valid_i=0, including pc_i==END_PC.
REQ-025 SHALL treat gp_i==0 at END_PC as FAIL with test_num_o=0.

Reset
REQ-026 SHALL on rst=1 (any state, including mid-RUN) enter IDLE next edge with done_o, pass_o, fail_o, timeout_o = 0, test_num_o = 0, cycle_count_o = 0.
REQ-027 SHALL ignore completion events in the cycle rst is high.

Configuration
REQ-028 SHALL, with TEST_MONITOR_TOHOST_EN defined, also finish on mem_we_i=1 and mem_addr_i==TOHOST_ADDR with mem_wdata_i[0]=1: wdata>>1==0 -> PASS, else FAIL with test_num_o=wdata>>1.
REQ-029 SHALL give END_PC detection priority over tohost store in the same cycle.
REQ-030 SHALL, without TEST_MONITOR_TOHOST_EN, omit the mem_* ports and snoop logic entirely; tohost writes with bit0=0 are ignored in either build.

Structure
REQ-031 SHALL place the state enum and verdict encoding in shared package rv_test_pkg.
REQ-032 SHALL implement the saturating cycle counter as sub-module sat_counter (params WIDTH, MAX; ports clk, rst, en, count, at_max).

Verification
REQ-033 SHALL cover: gp_i=1, pc_i=0x44 valid at cycle 20 -> pass_o=1 at cycle 21, cycle_count_o=20, others 0.
REQ-034 SHALL cover: gp_i=7 at pc_i=0x44 -> fail_o=1, test_num_o=3.
REQ-035 SHALL cover: TIMEOUT=50, no END_PC -> timeout_o=1 one cycle after count reaches 50, count holds 50.
REQ-036 SHALL cover: END_PC and count==TIMEOUT same cycle, gp_i=1 -> pass_o=1, timeout_o=0.
REQ-037 SHALL cover: rst pulsed at cycle 10 of RUN -> all outputs 0 next edge, count restarts from 0.
REQ-038 SHALL cover (macro on): store 0x0000000B to 0x1000 -> fail_o=1, test_num_o=5; store 0x1 -> pass_o=1.
